memory_bus_ram_slave: RTL
=========================

Name: memory_bus_ram_slave

Overview:
- Responder end of the MemoryBus packet protocol: a block-RAM-backed slave that accepts master-to-slave (ms) request packets and returns read data as slave-to-master (sm) packets tagged with the requester's ID.
- Sits behind the bus arbiter as scratch or scene memory for the ray tracing cores.
- Requests are applied in order.
- Read responses are queued in a small response FIFO so the slave never drops data when the master stalls smTaken.

Parameters:
- MASTER_ID_WIDTH, 8: width of msID/smID.
- ADDRESS_WIDTH, 32: width of msAddress.
- DATA_WIDTH, 16: width of msData/smData and of each RAM word.
- DEPTH, 1024: RAM words; power of two ≥ 2; index = msAddress[$clog2(DEPTH)-1:0].
- RESP_DEPTH, 4: response FIFO entries; power of two ≥ 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- msID  in  MASTER_ID_WIDTH  requester ID.
- msAddress  in  ADDRESS_WIDTH  word address.
- msData  in  DATA_WIDTH  write data.
- msWrite  in  1  1 = write, 0 = read.
- msValid  in  1  request valid.
- msTaken  out  1  request accepted this cycle.
- smID  out  MASTER_ID_WIDTH  ID of the read response.
- smData  out  DATA_WIDTH  read data.
- smValid  out  1  response valid.
- smTaken  in  1  master consumes the response.

Behaviour:
- Handshakes:
  - Request transfers on the rising edge where msValid && msTaken.
  - Response transfers on the rising edge where smValid && smTaken.
- Reset and reset values:
  - rst asserted: msTaken=0, smValid=0, smID=0, smData=0.
  - Pipeline valids and FIFO pointers/count clear immediately.
  - In-flight reads are discarded, and no response for them ever appears.
  - RAM contents are not cleared.
- msTaken (combinational):
  - Equals msValid && !rst && (msWrite || credit).
  - credit = (fifo_count + inflight_reads) < RESP_DEPTH, where inflight_reads is the count of valid read pipeline stages (0..2).
  - msTaken must not depend on smTaken.
- Writes:
  - RAM[index] <= msData at the accept edge.
  - No response is generated (see optional feature).
  - Upper address bits above the index are ignored, so addresses wrap modulo DEPTH.
- Reads, pipeline for a read accepted at edge k:
  - Edge k: RAM address and ID captured; stage1 valid.
  - Edge k+1: RAM output registered with the ID; stage2 valid.
  - Edge k+2: {ID, data} pushed into the FIFO.
  - The FIFO is first-word-fall-through, so with an empty FIFO smValid=1 in the cycle after edge k+2 (latency 3 edges).
- Ordering:
  - Responses return in acceptance order.
  - A write at edge k followed by a read of the same address at edge k+1 returns the new data.
  - Only one request is accepted per edge, so no same-edge read/write collision exists.
- FIFO:
  - Push and pop on the same edge are allowed; count is unchanged.
  - The credit rule guarantees a push never meets a full FIFO.
  - If RESP_DEPTH pushes would exceed capacity, that is a design bug; an assertion is required in simulation.
- Output stability: while smValid=1 and smTaken=0, smID and smData hold stable.
- Throughput: one request per cycle and one response per cycle sustained when smTaken is held high.
- Credit exhaustion:
  - Reads stall (msTaken=0) while writes continue to be accepted.
  - Read acceptance resumes in the same cycle a credit frees. A pop at edge e lets msTaken=1 in the cycle after e.

Optional Feature:
- Macro: MEMORY_BUS_WRITE_ACK_EN.
- Defined:
  - Every accepted write also consumes a credit: msTaken = msValid && !rst && credit for both kinds of request.
  - Each write produces a response {smID=msID, smData=0} through the same 3-edge pipeline, ordered with reads.
- Undefined: writes are posted with no response, as described above.

Test Plan:
- Reset then idle: assert rst mid-cycle -> msTaken=0, smValid=0 immediately; after release with msValid=0 -> smValid stays 0.
- Write then read back:
  - Stimulus: write ID=3, addr 0x10, data 0xBEEF, then read ID=5, addr 0x10 on the next cycle.
  - Required: smValid rises 3 edges after the read accept, with smID=5, smData=0xBEEF.
- Address wrap: write addr 0x400 (DEPTH=1024), data 0x1234 -> a read of addr 0x000 returns 0x1234.
- Backpressure and credits:
  - Stimulus: smTaken=0, issue 6 back-to-back reads (IDs 1..6).
  - Required: exactly 4 accepted (msTaken drops on the 5th); writes are still accepted.
  - Then raise smTaken: responses arrive with IDs 1,2,3,4 in order; reads 5 and 6 are then accepted and returned.
- Reset mid-operation: 2 reads in flight plus 2 in the FIFO, pulse rst -> no responses afterwards; previously written RAM data is still readable.
- Streaming with MEMORY_BUS_WRITE_ACK_EN:
  - Stimulus: alternate write and read each cycle for 20 cycles with smTaken=1.
  - Required: one response per cycle; write acks have smData=0 and the matching ID; reads return the last-written data.

Source files
------------

// File: rtl/memory_bus_ram_slave.sv
// MemoryBus RAM slave: block RAM behind the ms/sm packet handshake, read data returned tagged with requester ID.
// Latency: read accepted at edge k is visible on smValid after edge k+2 (3 edges) through a fall-through response FIFO.
// Backpressure: reads are credit-gated on FIFO + pipeline occupancy; writes are posted unless MEMORY_BUS_WRITE_ACK_EN.

// Generic fall-through FIFO used for the response queue.
// Latency: a push at edge e is visible on pop_vld/pop_dat right after edge e.
// Backpressure: none on push (caller guarantees space); pop only when pop_rdy.
module memory_bus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop;

    assign pop_vld = (count_q != '0);
    assign pop     = pop_vld && pop_rdy;
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_vld, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count state, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; pop_vld qualifies it.
    always_ff @(posedge clk) begin
        if (push_vld) mem_q[wr_ptr_q] <= push_dat;
    end

    // A push into a full FIFO without a pop means the upstream credit accounting is broken.
    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push_vld && !pop && (count_q == (AW+1)'(DEPTH))));
endmodule

// MemoryBus RAM slave top.
// Latency: 3 edges request-accept to response-valid with an empty response FIFO.
// Backpressure: msTaken drops for reads (and acked writes) when FIFO + in-flight reaches RESP_DEPTH.
module memory_bus_ram_slave #(
    parameter int MASTER_ID_WIDTH = 8,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 1024,
    parameter int RESP_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MASTER_ID_WIDTH-1:0] msID,
    input  logic [ADDRESS_WIDTH-1:0]   msAddress,
    input  logic [DATA_WIDTH-1:0]      msData,
    input  logic                       msWrite,
    input  logic                       msValid,
    output logic                       msTaken,
    output logic [MASTER_ID_WIDTH-1:0] smID,
    output logic [DATA_WIDTH-1:0]      smData,
    output logic                       smValid,
    input  logic                       smTaken
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(RESP_DEPTH) + 2;
    localparam int FW = MASTER_ID_WIDTH + DATA_WIDTH;
`ifdef MEMORY_BUS_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]       ram_q [DEPTH];
    logic [DATA_WIDTH-1:0]       ram_rd_q;
    logic [IW-1:0]               idx;
    logic                        accept, resp_accept, credit;
    logic [CW-1:0]               inflight, occupancy;
    logic [$clog2(RESP_DEPTH):0] fifo_count;
    logic                        s1_vld_q, s1_vld_d, s1_wr_q, s1_wr_d;
    logic                        s2_vld_q, s2_vld_d, s2_wr_q, s2_wr_d;
    logic [MASTER_ID_WIDTH-1:0]  s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic [IW-1:0]               s1_idx_q, s1_idx_d;
    logic [FW-1:0]               push_dat, pop_dat;
    logic                        pop_vld;
    logic                        unused_addr;

    // Upper address bits fold away so addresses wrap modulo DEPTH.
    assign idx         = msAddress[IW-1:0];
    assign unused_addr = ^msAddress[ADDRESS_WIDTH-1:IW];

    // Every response-producing request reserves a FIFO slot from acceptance until pop.
    assign inflight    = CW'(s1_vld_q) + CW'(s2_vld_q);
    assign occupancy   = CW'(fifo_count) + inflight;
    assign credit      = occupancy < CW'(RESP_DEPTH);
    assign msTaken     = msValid && !rst && ((msWrite && !WRITE_ACK) || credit);
    assign accept      = msValid && msTaken;
    assign resp_accept = accept && (!msWrite || WRITE_ACK);

    // Two-stage read pipeline: stage1 holds address/ID, stage2 pairs ID with RAM output.
    always_comb begin
        s1_vld_d = resp_accept;
        s1_id_d  = s1_id_q;
        s1_idx_d = s1_idx_q;
        s1_wr_d  = s1_wr_q;
        if (resp_accept) begin
            s1_id_d  = msID;
            s1_idx_d = idx;
            s1_wr_d  = msWrite;
        end
        s2_vld_d = s1_vld_q;
        s2_id_d  = s1_id_q;
        s2_wr_d  = s1_wr_q;
    end

    // Pipeline state; reset drops in-flight requests so they never produce a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            s1_idx_q <= '0;
            s1_wr_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= '0;
            s2_wr_q  <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_idx_q <= s1_idx_d;
            s1_wr_q  <= s1_wr_d;
            s2_vld_q <= s2_vld_d;
            s2_id_q  <= s2_id_d;
            s2_wr_q  <= s2_wr_d;
        end
    end

    // Block RAM with registered read; a write one edge ahead of the read's RAM access is seen.
    always_ff @(posedge clk) begin
        if (accept && msWrite) ram_q[idx] <= msData;
        ram_rd_q <= ram_q[s1_idx_q];
    end

    assign push_dat = {s2_id_q, (s2_wr_q ? {DATA_WIDTH{1'b0}} : ram_rd_q)};

    memory_bus_fifo #(
        .WIDTH (FW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (s2_vld_q),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .pop_rdy  (smTaken),
        .pop_dat  (pop_dat),
        .count    (fifo_count)
    );

    // Outputs are zero whenever no response is queued, including during reset.
    assign smValid = pop_vld;
    assign smID    = pop_vld ? pop_dat[FW-1:DATA_WIDTH] : '0;
    assign smData  = pop_vld ? pop_dat[DATA_WIDTH-1:0] : '0;
endmodule
